tb_sim_ctrl: RTL
================

# tb_sim_ctrl

Synthesizable simulation controller that supersedes the ad-hoc clock/reset, watchdog and pass/fail logic in the core testbench top. It sequences core reset and fetch enable, runs a programmable cycle watchdog, and aggregates pass/fail/exit reports from `NUM_CORES` subsystems into one registered verdict. It sits between the bench top and one or more `cv32e40p_tb_subsystem` instances. The `first`/`all` completion mode is new behaviour.

## Interface
- `NUM_CORES`, 1: number of monitored subsystems (1..16).
- `CNT_WIDTH`, 32: watchdog and cycle counter width.
- `RESET_WAIT_CYCLES`, 4: cycles core resets are held after `rst_ni` release; values below 1 are treated as 1.
- `WAIT_ALL`, 0: 0 means finish on the first core event; 1 means finish when every core has reported.

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous active-low reset.
- `max_cycles_i` in `CNT_WIDTH`: watchdog limit; 0 disables it; sampled every cycle.
- `tests_passed_i` in `NUM_CORES`: per-core pass pulse/level.
- `tests_failed_i` in `NUM_CORES`: per-core fail.
- `exit_valid_i` in `NUM_CORES`: per-core exit report.
- `exit_value_i` in `NUM_CORES*32`: per-core exit code; core k occupies `[32k+31:32k]`.
- `core_rst_no` out `NUM_CORES`: per-core active-low reset.
- `fetch_enable_o` out `NUM_CORES`: per-core fetch enable.
- `done_o` out 1: verdict valid; sticky.
- `status_o` out 3: `sim_status_e`.
- `exit_value_o` out 32: exit code of the deciding core.
- `done_core_o` out `max(1,$clog2(NUM_CORES))`: index of the deciding core.
- `cycle_cnt_o` out `CNT_WIDTH`: number of run cycles elapsed.

## Operation
- FSM has three states.
  - `S_RESET` → `S_RUN` after `RESET_WAIT_CYCLES` cycles, counted by a wait counter.
  - `S_RUN` → `S_DONE` on completion or timeout.
  - `S_DONE` is terminal until `rst_ni` is asserted.
- Per-state outputs:
  - `S_RESET`: `core_rst_no`=0, `fetch_enable_o`=0.
  - `S_RUN`: both all-ones.
  - `S_DONE`: `core_rst_no` all-ones, `fetch_enable_o`=0.
- Per-core outcome, highest priority first:
  - `tests_failed_i` → `FAIL`.
  - `exit_valid_i` with a nonzero value → `EXIT_ERR`.
  - `exit_valid_i` with a zero value → `EXIT_OK`.
  - `tests_passed_i` → `PASS`.
- Status encoding and severity: `PASS`=0, `EXIT_OK`=1, `EXIT_ERR`=2, `FAIL`=3, `TIMEOUT`=4. Severity is the numeric value.
- Report inputs are ignored outside `S_RUN`.
- `WAIT_ALL`=0:
  - The first cycle with any event decides the verdict.
  - If several cores report in the same cycle, the lowest index wins.
- `WAIT_ALL`=1:
  - Each core's first outcome and exit value are latched into a finished mask; later reports from that core are ignored.
  - Completion occurs when the mask is all-ones.
  - Verdict is the maximum severity; ties go to the lowest index.
- `exit_value_o` carries the latched exit code of the deciding core. It is 0 for `PASS`, `FAIL` and `TIMEOUT`.
- Watchdog:
  - Timeout occurs in `S_RUN` when `max_cycles_i`≠0 and `cycle_cnt_q` ≥ `max_cycles_i`, and completion does not occur in the same cycle. Completion wins a tie.
  - On timeout: status `TIMEOUT`, `done_core_o`=0, `exit_value_o`=0.
- Cycle counter:
  - Cleared in `S_RESET`.
  - Increments each `S_RUN` cycle and saturates at all-ones.
  - Frozen in `S_DONE`.

## Timing
- Reset values: all outputs 0, state `S_RESET`.
- `core_rst_no` rises at the `RESET_WAIT_CYCLES`-th rising edge after `rst_ni` deasserts.
- `cycle_cnt_o` is 0 in the first `S_RUN` cycle.
- All outputs are registered. An event sampled at edge N makes `done_o`, `status_o`, `exit_value_o` and `done_core_o` valid after edge N. They hold in `S_DONE`.
- Asserting `rst_ni` at any time, including mid-run or in `S_DONE`, returns all outputs to reset values immediately (asynchronous). The sequence then restarts.

## Structure
- `tb_sim_pkg` holds:
  - `sim_status_e`;
  - the `fsm_state_e` state enum;
  - the function `outcome_of(failed, valid, value)` returning `sim_status_e`.
- Sub-module `tb_outcome_arbiter` is a combinational reducer over `NUM_CORES` statuses. Its outputs are the maximum severity, the lowest index among ties, and that core's value. It is used for the `WAIT_ALL`=1 reduction.
- The FSM, counters and per-core latches live in `tb_sim_ctrl`.

## Test plan
- `RESET_WAIT_CYCLES`=4, release `rst_ni` at edge 0:
  - `core_rst_no`/`fetch_enable_o` go to 1 after edge 4;
  - `cycle_cnt_o`=0 then increments by 1 per cycle.
- `NUM_CORES`=1, `WAIT_ALL`=0, `exit_valid_i`=1 with value 0x2A at run cycle 10:
  - `done_o`=1, `status_o`=`EXIT_ERR`, `exit_value_o`=0x2A, `fetch_enable_o`=0, `cycle_cnt_o` frozen at 11.
- `NUM_CORES`=4, `WAIT_ALL`=0, cores 2 and 1 assert `tests_passed_i` in the same cycle:
  - `status_o`=`PASS`, `done_core_o`=1.
- `NUM_CORES`=4, `WAIT_ALL`=1, cores 0–3 report `PASS`, `EXIT_OK`(0), `FAIL`, `PASS` in different cycles:
  - `done_o` rises only after the last report;
  - `status_o`=`FAIL`, `done_core_o`=2.
- `max_cycles_i`=20, no events:
  - `status_o`=`TIMEOUT` after 21 run cycles.
  - Repeat with `tests_passed_i` in the timeout cycle: `status_o`=`PASS`.
  - `max_cycles_i`=0 never times out.
- Assert `rst_ni` mid-run and in `S_DONE`:
  - outputs return to 0 asynchronously;
  - the reset sequence repeats.

Source files
------------

// File: rtl/tb_sim_pkg.sv
// Shared types for the simulation controller: verdict encoding, FSM states
// and the per-core report classifier.
package tb_sim_pkg;

    // Numeric value doubles as severity when several cores are reduced.
    typedef enum logic [2:0] {
        SIM_PASS     = 3'd0,
        SIM_EXIT_OK  = 3'd1,
        SIM_EXIT_ERR = 3'd2,
        SIM_FAIL     = 3'd3,
        SIM_TIMEOUT  = 3'd4
    } sim_status_e;

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_RUN   = 2'd1,
        S_DONE  = 2'd2
    } fsm_state_e;

    function automatic sim_status_e outcome_of(input logic failed, input logic valid,
                                               input logic [31:0] value);
        if (failed)
            return SIM_FAIL;
        else if (valid && value != 32'd0)
            return SIM_EXIT_ERR;
        else if (valid)
            return SIM_EXIT_OK;
        else
            return SIM_PASS;
    endfunction

endpackage

// File: rtl/tb_sim_ctrl_if.sv
// Per-core report and control bundle between the controller and the monitored
// subsystems; master is the controller side.
interface tb_sim_ctrl_if #(
    parameter int NUM_CORES = 1
);
    logic [NUM_CORES-1:0]    tests_passed_i;
    logic [NUM_CORES-1:0]    tests_failed_i;
    logic [NUM_CORES-1:0]    exit_valid_i;
    logic [NUM_CORES*32-1:0] exit_value_i;
    logic [NUM_CORES-1:0]    core_rst_no;
    logic [NUM_CORES-1:0]    fetch_enable_o;

    modport master (
        input  tests_passed_i, tests_failed_i, exit_valid_i, exit_value_i,
        output core_rst_no, fetch_enable_o
    );

    modport slave (
        output tests_passed_i, tests_failed_i, exit_valid_i, exit_value_i,
        input  core_rst_no, fetch_enable_o
    );
endinterface

// File: rtl/tb_outcome_arbiter.sv
// Combinational reducer: picks the most severe status, lowest index on ties,
// and forwards that core's exit value.
module tb_outcome_arbiter
    import tb_sim_pkg::*;
#(
    parameter int NUM_CORES = 1,
    parameter int IDX_W     = 1
) (
    input  sim_status_e       status_i [NUM_CORES],
    input  logic [31:0]       value_i  [NUM_CORES],
    output sim_status_e       status_o,
    output logic [IDX_W-1:0]  idx_o,
    output logic [31:0]       value_o
);

    always_comb begin
        status_o = status_i[0];
        idx_o    = '0;
        value_o  = value_i[0];
        // Strict compare keeps the earliest index when severities are equal.
        for (int i = 1; i < NUM_CORES; i++) begin
            if (status_i[i] > status_o) begin
                status_o = status_i[i];
                idx_o    = IDX_W'(i);
                value_o  = value_i[i];
            end
        end
    end

endmodule

// File: rtl/tb_sim_ctrl.sv
// Simulation controller: sequences core reset/fetch enable, runs the cycle
// watchdog and folds per-core reports into one registered verdict.
module tb_sim_ctrl
    import tb_sim_pkg::*;
#(
    parameter int NUM_CORES         = 1,
    parameter int CNT_WIDTH         = 32,
    parameter int RESET_WAIT_CYCLES = 4,
    parameter int WAIT_ALL          = 0,
    localparam int IDX_W            = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [CNT_WIDTH-1:0] max_cycles_i,
    tb_sim_ctrl_if.master        core_bus,
    output logic                 done_o,
    output sim_status_e          status_o,
    output logic [31:0]          exit_value_o,
    output logic [IDX_W-1:0]     done_core_o,
    output logic [CNT_WIDTH-1:0] cycle_cnt_o
);

    localparam int RW = (RESET_WAIT_CYCLES < 1) ? 1 : RESET_WAIT_CYCLES;

    fsm_state_e           state_reg;
    logic [31:0]          wait_cnt_reg;
    logic [CNT_WIDTH-1:0] cycle_cnt_reg;
    logic [NUM_CORES-1:0] core_rst_reg;
    logic [NUM_CORES-1:0] fetch_en_reg;
    logic                 done_reg;
    sim_status_e          status_reg;
    logic [31:0]          exit_value_reg;
    logic [IDX_W-1:0]     done_core_reg;

    logic [NUM_CORES-1:0] event_vec;
    logic [NUM_CORES-1:0] fin_mask;
    sim_status_e          core_status   [NUM_CORES];
    logic [31:0]          core_value    [NUM_CORES];
    sim_status_e          merged_status [NUM_CORES];
    logic [31:0]          merged_value  [NUM_CORES];

    for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_core
        logic [31:0] raw_value;
        logic        fin_reg;
        sim_status_e fin_status_reg;
        logic [31:0] fin_value_reg;

        assign raw_value         = core_bus.exit_value_i[32*gi +: 32];
        assign event_vec[gi]     = core_bus.tests_passed_i[gi] | core_bus.tests_failed_i[gi]
                                 | core_bus.exit_valid_i[gi];
        assign core_status[gi]   = outcome_of(core_bus.tests_failed_i[gi],
                                              core_bus.exit_valid_i[gi], raw_value);
        assign core_value[gi]    = (core_bus.exit_valid_i[gi] && !core_bus.tests_failed_i[gi])
                                 ? raw_value : 32'd0;
        assign fin_mask[gi]      = fin_reg;
        // A core reporting in the completing cycle is seen before it is latched.
        assign merged_status[gi] = fin_reg ? fin_status_reg : core_status[gi];
        assign merged_value[gi]  = fin_reg ? fin_value_reg  : core_value[gi];

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                fin_reg        <= 1'b0;
                fin_status_reg <= SIM_PASS;
                fin_value_reg  <= 32'd0;
            end else if (state_reg == S_RESET) begin
                fin_reg        <= 1'b0;
                fin_status_reg <= SIM_PASS;
                fin_value_reg  <= 32'd0;
            end else if (state_reg == S_RUN && event_vec[gi] && !fin_reg) begin
                fin_reg        <= 1'b1;
                fin_status_reg <= core_status[gi];
                fin_value_reg  <= core_value[gi];
            end
        end
    end

    sim_status_e      arb_status;
    logic [IDX_W-1:0] arb_idx;
    logic [31:0]      arb_value;

    tb_outcome_arbiter #(
        .NUM_CORES (NUM_CORES),
        .IDX_W     (IDX_W)
    ) u_arbiter (
        .status_i (merged_status),
        .value_i  (merged_value),
        .status_o (arb_status),
        .idx_o    (arb_idx),
        .value_o  (arb_value)
    );

    sim_status_e      first_status;
    logic [IDX_W-1:0] first_idx;
    logic [31:0]      first_value;

    always_comb begin
        first_status = SIM_PASS;
        first_idx    = '0;
        first_value  = 32'd0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (event_vec[i]) begin
                first_status = core_status[i];
                first_idx    = IDX_W'(i);
                first_value  = core_value[i];
            end
        end
    end

    logic             complete;
    logic             timeout;
    sim_status_e      win_status;
    logic [IDX_W-1:0] win_idx;
    logic [31:0]      win_value;

    always_comb begin
        complete   = 1'b0;
        win_status = SIM_PASS;
        win_idx    = '0;
        win_value  = 32'd0;
        if (WAIT_ALL != 0) begin
            complete   = &(fin_mask | event_vec);
            win_status = arb_status;
            win_idx    = arb_idx;
            win_value  = arb_value;
        end else begin
            complete   = |event_vec;
            win_status = first_status;
            win_idx    = first_idx;
            win_value  = first_value;
        end
    end

    assign timeout = (max_cycles_i != '0) && (cycle_cnt_reg >= max_cycles_i) && !complete;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg      <= S_RESET;
            wait_cnt_reg   <= 32'd0;
            cycle_cnt_reg  <= '0;
            core_rst_reg   <= '0;
            fetch_en_reg   <= '0;
            done_reg       <= 1'b0;
            status_reg     <= SIM_PASS;
            exit_value_reg <= 32'd0;
            done_core_reg  <= '0;
        end else begin
            case (state_reg)
                S_RESET: begin
                    cycle_cnt_reg <= '0;
                    if (wait_cnt_reg == 32'(RW - 1)) begin
                        state_reg    <= S_RUN;
                        wait_cnt_reg <= 32'd0;
                        core_rst_reg <= '1;
                        fetch_en_reg <= '1;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 32'd1;
                    end
                end
                S_RUN: begin
                    if (cycle_cnt_reg != {CNT_WIDTH{1'b1}})
                        cycle_cnt_reg <= cycle_cnt_reg + CNT_WIDTH'(1);
                    if (complete) begin
                        state_reg      <= S_DONE;
                        fetch_en_reg   <= '0;
                        done_reg       <= 1'b1;
                        status_reg     <= win_status;
                        exit_value_reg <= win_value;
                        done_core_reg  <= win_idx;
                    end else if (timeout) begin
                        state_reg      <= S_DONE;
                        fetch_en_reg   <= '0;
                        done_reg       <= 1'b1;
                        status_reg     <= SIM_TIMEOUT;
                        exit_value_reg <= 32'd0;
                        done_core_reg  <= '0;
                    end
                end
                S_DONE: begin
                end
                default: state_reg <= S_RESET;
            endcase
        end
    end

    assign core_bus.core_rst_no    = core_rst_reg;
    assign core_bus.fetch_enable_o = fetch_en_reg;
    assign done_o                  = done_reg;
    assign status_o                = status_reg;
    assign exit_value_o            = exit_value_reg;
    assign done_core_o             = done_core_reg;
    assign cycle_cnt_o             = cycle_cnt_reg;

endmodule
